// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: types and constants shared by the pipeline controller.
//   state_t       - sequencer states (IDLE .. DONE, 3-bit encoding)
//   DRAIN_CYCLES  - number of bubble-injection cycles before the dump
//   ctrl_out_t    - bundle of every registered strobe the controller drives
//   decode_state  - maps a state to its strobe pattern (flush excluded)
package pipeline_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MEM_RST  = 3'd1,
        LOAD     = 3'd2,
        CORE_RST = 3'd3,
        RUN      = 3'd4,
        DRAIN    = 3'd5,
        DUMP     = 3'd6,
        DONE     = 3'd7
    } state_t;

    localparam int unsigned DRAIN_CYCLES = 2;

    typedef struct packed {
        logic im_reset;
        logic dm_reset;
        logic im_read;
        logic dm_read;
        logic im_write;
        logic dm_write;
        logic pc_reset;
        logic rb_reset;
        logic tf_reset;
        logic ifid_reset;
        logic ifid_enable;
        logic exwb_reset;
        logic exwb_enable;
        logic busy;
        logic done;
    } ctrl_out_t;

    function automatic ctrl_out_t decode_state(input state_t s);
        ctrl_out_t o;
        o = '0;
        o.busy = (s != IDLE) && (s != DONE);
        case (s)
            MEM_RST: begin
                o.im_reset = 1'b1;
                o.dm_reset = 1'b1;
            end
            LOAD: begin
                o.im_read = 1'b1;
                o.dm_read = 1'b1;
            end
            CORE_RST: begin
                o.pc_reset   = 1'b1;
                o.rb_reset   = 1'b1;
                o.tf_reset   = 1'b1;
                o.ifid_reset = 1'b1;
                o.exwb_reset = 1'b1;
            end
            RUN: begin
                o.ifid_enable = 1'b1;
                o.exwb_enable = 1'b1;
            end
            DRAIN: begin
                o.ifid_enable = 1'b1;
                o.exwb_enable = 1'b1;
                o.ifid_reset  = 1'b1;
            end
            DUMP: begin
                o.im_write = 1'b1;
                o.dm_write = 1'b1;
            end
            DONE: o.done = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: control bundle between the sequencer and the processor top.
//   start, halt_req, in_pc_write       - requests into the controller
//   im_/dm_ RESET/read_file/write_file - memory reset, load and dump strobes
//   pc_/rb_/tf_RESET                   - core state resets
//   reg_* RESET/ENABLE                 - pipeline-register controls
//   busy, done, cycle_count            - status
// modport master is the controller side, slave is the processor side.
interface pipeline_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             start;
    logic             halt_req;
    logic             in_pc_write;
    logic             im_RESET;
    logic             dm_RESET;
    logic             im_read_file;
    logic             dm_read_file;
    logic             im_write_file;
    logic             dm_write_file;
    logic             pc_RESET;
    logic             rb_RESET;
    logic             tf_RESET;
    logic             reg_ifid_exmem_RESET;
    logic             reg_ifid_exmem_ENABLE;
    logic             reg_exmem_wb_RESET;
    logic             reg_exmem_wb_ENABLE;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        input  start, halt_req, in_pc_write,
        output im_RESET, dm_RESET, im_read_file, dm_read_file,
               im_write_file, dm_write_file, pc_RESET, rb_RESET, tf_RESET,
               reg_ifid_exmem_RESET, reg_ifid_exmem_ENABLE,
               reg_exmem_wb_RESET, reg_exmem_wb_ENABLE,
               busy, done, cycle_count
    );

    modport slave (
        output start, halt_req, in_pc_write,
        input  im_RESET, dm_RESET, im_read_file, dm_read_file,
               im_write_file, dm_write_file, pc_RESET, rb_RESET, tf_RESET,
               reg_ifid_exmem_RESET, reg_ifid_exmem_ENABLE,
               reg_exmem_wb_RESET, reg_exmem_wb_ENABLE,
               busy, done, cycle_count
    );
endinterface

// File: rtl/pipeline_ctrl_cycle_counter.sv
// ctrl_cycle_counter: saturating RUN-cycle counter.
//   clk, rst - clock, synchronous active-high reset
//   clr      - synchronous clear (lower priority than rst)
//   en       - count this cycle
//   count    - current value, holds at all-ones
//   tc       - count equals RUN_CYCLES-1 (compared at full width, so a
//              narrow counter that saturates below it never signals tc)
module ctrl_cycle_counter #(
    parameter int unsigned RUN_CYCLES = 3333,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             tc
);
    localparam int unsigned CMP_W = (CNT_W > 32) ? CNT_W : 32;
    localparam logic [CMP_W-1:0] TC_VAL = CMP_W'(RUN_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign tc = (CMP_W'(count) == TC_VAL);

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: boot / run / drain / dump sequencer for the pipelined core.
//   CLK, RESET - clock, synchronous active-high reset to IDLE
//   bus        - pipeline_ctrl_if.master: start/halt_req/in_pc_write in,
//                memory, core and pipeline-register strobes plus status out
// Outputs are decoded from the next state and registered, so each strobe is
// high for exactly the cycles the FSM spends in the corresponding state.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned RUN_CYCLES = 3333,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    pipeline_ctrl_if.master  bus
);
    state_t     state;
    state_t     nxt;
    logic [1:0] drain_idx;
    ctrl_out_t  outs;
    ctrl_out_t  outs_nxt;
    logic       run_tc;
    logic       cnt_clr;
    logic       cnt_en;
    logic [CNT_W-1:0] count;

    assign cnt_clr = ((state == IDLE) || (state == DONE)) && bus.start;
    assign cnt_en  = (state == RUN);

    ctrl_cycle_counter #(
        .RUN_CYCLES (RUN_CYCLES),
        .CNT_W      (CNT_W)
    ) u_cnt (
        .clk   (CLK),
        .rst   (RESET),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (count),
        .tc    (run_tc)
    );

    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE: if (bus.start) nxt = MEM_RST;
            MEM_RST:    nxt = LOAD;
            LOAD:       nxt = CORE_RST;
            CORE_RST:   nxt = RUN;
            RUN:        if (bus.halt_req || run_tc) nxt = DRAIN;
            DRAIN:      if (drain_idx == 2'(DRAIN_CYCLES - 1)) nxt = DUMP;
            DUMP:       nxt = DONE;
            default:    nxt = IDLE;
        endcase
    end

    // A PC write seen in RUN kills both younger stages in the following
    // cycle, which is either RUN or the first DRAIN cycle; both keep the
    // enables high, so the overlay only needs to raise the two resets.
    always_comb begin
        outs_nxt = decode_state(nxt);
        if ((state == RUN) && bus.in_pc_write) begin
            outs_nxt.ifid_reset = 1'b1;
            outs_nxt.exwb_reset = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            drain_idx <= '0;
            outs      <= '0;
        end else begin
            state     <= nxt;
            drain_idx <= ((state == DRAIN) && (nxt == DRAIN)) ? drain_idx + 2'd1 : '0;
            outs      <= outs_nxt;
        end
    end

    assign bus.im_RESET              = outs.im_reset;
    assign bus.dm_RESET              = outs.dm_reset;
    assign bus.im_read_file          = outs.im_read;
    assign bus.dm_read_file          = outs.dm_read;
    assign bus.im_write_file         = outs.im_write;
    assign bus.dm_write_file         = outs.dm_write;
    assign bus.pc_RESET              = outs.pc_reset;
    assign bus.rb_RESET              = outs.rb_reset;
    assign bus.tf_RESET              = outs.tf_reset;
    assign bus.reg_ifid_exmem_RESET  = outs.ifid_reset;
    assign bus.reg_ifid_exmem_ENABLE = outs.ifid_enable;
    assign bus.reg_exmem_wb_RESET    = outs.exwb_reset;
    assign bus.reg_exmem_wb_ENABLE   = outs.exwb_enable;
    assign bus.busy                  = outs.busy;
    assign bus.done                  = outs.done;
    assign bus.cycle_count           = count;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed bench for pipeline_ctrl.
// Two instances: A (RUN_CYCLES=5, CNT_W=32) and B (RUN_CYCLES=20, CNT_W=3).
// A phase-timeline model predicts every output on every cycle; directed
// literal checks pin key points of the sequence.
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    pipeline_ctrl_if #(.CNT_W(32)) ia();
    pipeline_ctrl_if #(.CNT_W(3))  ib();

    pipeline_ctrl #(.RUN_CYCLES(5), .CNT_W(32)) dut_a (
        .CLK   (clk),
        .RESET (rst),
        .bus   (ia)
    );

    pipeline_ctrl #(.RUN_CYCLES(20), .CNT_W(3)) dut_b (
        .CLK   (clk),
        .RESET (rst),
        .bus   (ib)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Bit order: imR dmR imRd dmRd imW dmW pc rb tf ifidR ifidE exwbR exwbE busy done
    logic [14:0] got_a, got_b;
    assign got_a = {ia.im_RESET, ia.dm_RESET, ia.im_read_file, ia.dm_read_file,
                    ia.im_write_file, ia.dm_write_file, ia.pc_RESET, ia.rb_RESET,
                    ia.tf_RESET, ia.reg_ifid_exmem_RESET, ia.reg_ifid_exmem_ENABLE,
                    ia.reg_exmem_wb_RESET, ia.reg_exmem_wb_ENABLE, ia.busy, ia.done};
    assign got_b = {ib.im_RESET, ib.dm_RESET, ib.im_read_file, ib.dm_read_file,
                    ib.im_write_file, ib.dm_write_file, ib.pc_RESET, ib.rb_RESET,
                    ib.tf_RESET, ib.reg_ifid_exmem_RESET, ib.reg_ifid_exmem_ENABLE,
                    ib.reg_exmem_wb_RESET, ib.reg_exmem_wb_ENABLE, ib.busy, ib.done};

    // ---------------- model: phase timeline ----------------
    string  m_phase [2];
    int     m_left  [2];
    longint m_runs  [2];
    bit     m_flush [2];
    bit     m_valid = 1'b0;
    int     m_rc    [2] = '{5, 20};
    int     m_cw    [2] = '{32, 3};

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic string follow(input string p);
        case (p)
            "MEM":   return "LOAD";
            "LOAD":  return "CORE";
            "CORE":  return "RUN";
            "DRAIN": return "DUMP";
            "DUMP":  return "DONE";
            default: return "IDLE";
        endcase
    endfunction

    function automatic int span(input string p);
        return (p == "DRAIN") ? 2 : 1;
    endfunction

    task automatic model_step(input int d, input bit r, input bit s, input bit h, input bit p);
        bit fl;
        bit term;
        if (r) begin
            m_phase[d] = "IDLE";
            m_left[d]  = 0;
            m_runs[d]  = 0;
            m_flush[d] = 1'b0;
            return;
        end
        fl = (m_phase[d] == "RUN") && p;
        if (m_phase[d] == "IDLE" || m_phase[d] == "DONE") begin
            if (s) begin
                m_phase[d] = "MEM";
                m_left[d]  = span("MEM");
                m_runs[d]  = 0;
            end
        end else if (m_phase[d] == "RUN") begin
            term = (sat(m_runs[d], m_cw[d]) == longint'(m_rc[d] - 1));
            m_runs[d]++;
            if (h || term) begin
                m_phase[d] = "DRAIN";
                m_left[d]  = span("DRAIN");
            end
        end else begin
            m_left[d]--;
            if (m_left[d] == 0) begin
                m_phase[d] = follow(m_phase[d]);
                m_left[d]  = span(m_phase[d]);
            end
        end
        m_flush[d] = fl;
    endtask

    function automatic logic [14:0] exp_vec(input string ph, input bit fl);
        logic [14:0] v;
        v = '0;
        case (ph)
            "MEM":   begin v[14] = 1'b1; v[13] = 1'b1; end
            "LOAD":  begin v[12] = 1'b1; v[11] = 1'b1; end
            "CORE":  begin v[8] = 1'b1; v[7] = 1'b1; v[6] = 1'b1; v[5] = 1'b1; v[3] = 1'b1; end
            "RUN":   begin v[4] = 1'b1; v[2] = 1'b1; end
            "DRAIN": begin v[5] = 1'b1; v[4] = 1'b1; v[2] = 1'b1; end
            "DUMP":  begin v[10] = 1'b1; v[9] = 1'b1; end
            "DONE":  v[0] = 1'b1;
            default: ;
        endcase
        if (ph != "IDLE" && ph != "DONE") v[1] = 1'b1;
        if (fl) begin v[5] = 1'b1; v[3] = 1'b1; end
        return v;
    endfunction

    always @(posedge clk) begin
        model_step(0, rst, ia.start, ia.halt_req, ia.in_pc_write);
        model_step(1, rst, ib.start, ib.halt_req, ib.in_pc_write);
        if (rst) m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("A.outputs", 64'(got_a), 64'(exp_vec(m_phase[0], m_flush[0])));
            check("A.cycle_count", 64'(ia.cycle_count), 64'(sat(m_runs[0], 32)));
            check("B.outputs", 64'(got_b), 64'(exp_vec(m_phase[1], m_flush[1])));
            check("B.cycle_count", 64'(ib.cycle_count), 64'(sat(m_runs[1], 3)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1;
        ia.start = 1'b0; ia.halt_req = 1'b0; ia.in_pc_write = 1'b0;
        ib.start = 1'b0; ib.halt_req = 1'b0; ib.in_pc_write = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("reset_busy", ia.busy, 1'b0);
        check("reset_count", ia.cycle_count, 0);
        check("reset_done_b", ib.done, 1'b0);

        // boot and a full 5-cycle run
        ia.start = 1'b1; tick(); ia.start = 1'b0;
        check("boot_im_reset", ia.im_RESET, 1'b1);
        check("boot_busy", ia.busy, 1'b1);
        tick();
        check("boot_read_file", ia.dm_read_file, 1'b1);
        check("boot_read_no_mrst", ia.im_RESET, 1'b0);
        tick();
        check("boot_pc_reset", ia.pc_RESET, 1'b1);
        check("boot_exwb_reset", ia.reg_exmem_wb_RESET, 1'b1);
        check("boot_en_low", ia.reg_ifid_exmem_ENABLE, 1'b0);
        tick();
        check("run1_enable", ia.reg_exmem_wb_ENABLE, 1'b1);
        check("run1_count", ia.cycle_count, 0);
        repeat (4) tick();
        check("run5_enable", ia.reg_ifid_exmem_ENABLE, 1'b1);
        check("run5_count", ia.cycle_count, 4);
        tick();
        check("drain1_ifid", ia.reg_ifid_exmem_RESET, 1'b1);
        check("drain1_exwb", ia.reg_exmem_wb_RESET, 1'b0);
        check("drain1_count", ia.cycle_count, 5);
        tick();
        check("drain2_ifid", ia.reg_ifid_exmem_RESET, 1'b1);
        tick();
        check("dump_write", ia.im_write_file, 1'b1);
        check("dump_en_low", ia.reg_ifid_exmem_ENABLE, 1'b0);
        ia.start = 1'b1;
        tick(); ia.start = 1'b0;
        check("done_flag", ia.done, 1'b1);
        check("done_busy", ia.busy, 1'b0);
        check("done_count", ia.cycle_count, 5);

        // flush pulses during RUN, start in RUN ignored
        ia.start = 1'b1; tick(); ia.start = 1'b0;
        check("restart_done_clr", ia.done, 1'b0);
        check("restart_count_clr", ia.cycle_count, 0);
        repeat (3) tick();
        ia.in_pc_write = 1'b1; tick(); ia.in_pc_write = 1'b0; ia.start = 1'b1;
        check("flush1_ifid", ia.reg_ifid_exmem_RESET, 1'b1);
        check("flush1_exwb", ia.reg_exmem_wb_RESET, 1'b1);
        check("flush1_en", ia.reg_ifid_exmem_ENABLE, 1'b1);
        tick(); ia.start = 1'b0;
        check("flush1_end", ia.reg_exmem_wb_RESET, 1'b0);
        check("start_in_run", ia.im_RESET, 1'b0);
        ia.in_pc_write = 1'b1; tick();
        check("flush2a_exwb", ia.reg_exmem_wb_RESET, 1'b1);
        tick(); ia.in_pc_write = 1'b0;
        check("flush2b_exwb", ia.reg_exmem_wb_RESET, 1'b1);
        check("flush2b_count", ia.cycle_count, 4);
        tick();
        check("flush2_drain_exwb", ia.reg_exmem_wb_RESET, 1'b0);
        repeat (3) tick();
        check("flush_run_done", ia.done, 1'b1);

        // halt together with a PC write
        ia.start = 1'b1; tick(); ia.start = 1'b0;
        repeat (3) tick();
        tick();
        ia.halt_req = 1'b1; ia.in_pc_write = 1'b1; tick();
        ia.halt_req = 1'b0; ia.in_pc_write = 1'b0;
        check("hf_drain1_ifid", ia.reg_ifid_exmem_RESET, 1'b1);
        check("hf_drain1_exwb", ia.reg_exmem_wb_RESET, 1'b1);
        check("hf_drain1_count", ia.cycle_count, 2);
        tick();
        check("hf_drain2_ifid", ia.reg_ifid_exmem_RESET, 1'b1);
        check("hf_drain2_exwb", ia.reg_exmem_wb_RESET, 1'b0);
        tick(); tick();
        check("hf_done", ia.done, 1'b1);

        // RESET during LOAD
        ia.start = 1'b1; tick(); ia.start = 1'b0; tick();
        check("rl_in_load", ia.im_read_file, 1'b1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("rl_busy", ia.busy, 1'b0);
        check("rl_read", ia.im_read_file, 1'b0);
        tick();
        check("rl_no_core", ia.pc_RESET, 1'b0);

        // RESET during DRAIN
        ia.start = 1'b1; tick(); ia.start = 1'b0;
        repeat (3) tick();
        ia.halt_req = 1'b1; tick(); ia.halt_req = 1'b0;
        check("rd_in_drain", ia.reg_ifid_exmem_RESET, 1'b1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("rd_busy", ia.busy, 1'b0);
        check("rd_count", ia.cycle_count, 0);
        tick();
        check("rd_no_dump", ia.im_write_file, 1'b0);
        check("rd_no_done", ia.done, 1'b0);
        tick();

        // narrow counter saturates and never reaches the terminal count
        ib.start = 1'b1; tick(); ib.start = 1'b0;
        repeat (3) tick();
        repeat (25) tick();
        check("sat_busy", ib.busy, 1'b1);
        check("sat_enable", ib.reg_ifid_exmem_ENABLE, 1'b1);
        check("sat_count", ib.cycle_count, 7);
        ib.halt_req = 1'b1; tick(); ib.halt_req = 1'b0;
        check("sat_drain", ib.reg_ifid_exmem_RESET, 1'b1);
        check("sat_drain_count", ib.cycle_count, 7);
        repeat (3) tick();
        check("sat_done", ib.done, 1'b1);
        tick(); tick();
        check("sat_done_hold", ib.done, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
